// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant bundle between the four bus masters and the arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if;
   logic       m0_req;
   logic       m1_req;
   logic       m2_req;
   logic       m3_req;
   logic       m0_grnt;
   logic       m1_grnt;
   logic       m2_grnt;
   logic       m3_grnt;
   logic [1:0] owner;
   logic       grnt_chg;

   modport master (
      output m0_req, m1_req, m2_req, m3_req,
      input  m0_grnt, m1_grnt, m2_grnt, m3_grnt, owner, grnt_chg
   );

   modport slave (
      input  m0_req, m1_req, m2_req, m3_req,
      output m0_grnt, m1_grnt, m2_grnt, m3_grnt, owner, grnt_chg
   );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Sticky round-robin arbiter for four bus masters, one-hot grants.
//               Optional hold timeout enabled by defining BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  wire           clk,
   input  wire           rst_n,
   bus_arbiter_if.slave  bus
);

   logic [1:0] r_owner;
   logic [3:0] r_grnt;
   logic       r_grnt_chg;

   logic [3:0] w_req;
   logic       w_owner_req;
   logic       w_force;
   logic       w_rr_found;
   logic [1:0] w_rr_pick;
   logic [1:0] w_next;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_chk
      $error("bus_arbiter: MAX_HOLD must be within 2..255");
   end

   assign w_req       = {bus.m3_req, bus.m2_req, bus.m1_req, bus.m0_req};
   assign w_owner_req = w_req[r_owner];

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] r_hold_cnt;
   logic [3:0] w_others;
   logic       w_contend;

   always_comb begin
      w_others          = w_req;
      w_others[r_owner] = 1'b0;
   end

   assign w_contend = w_owner_req && (|w_others);
   assign w_force   = w_contend && (r_hold_cnt == C_HOLD_LAST);

   // Counts only while the owner is actually blocking someone else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= 8'd0;
      end else if (w_next != r_owner || !w_contend) begin
         r_hold_cnt <= 8'd0;
      end else begin
         r_hold_cnt <= r_hold_cnt + 8'd1;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_pick  = r_owner;
      for (int i = 3; i >= 1; i--) begin
         if (w_req[2'(r_owner + 2'(i))]) begin
            w_rr_found = 1'b1;
            w_rr_pick  = 2'(r_owner + 2'(i));
         end
      end
   end

   always_comb begin
      w_next = r_owner;
      if (!(w_owner_req && !w_force) && w_rr_found) begin
         w_next = w_rr_pick;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner    <= 2'd0;
         r_grnt     <= 4'b0001;
         r_grnt_chg <= 1'b0;
      end else begin
         r_owner    <= w_next;
         r_grnt     <= 4'b0001 << w_next;
         r_grnt_chg <= (w_next != r_owner);
      end
   end

   assign bus.m0_grnt  = r_grnt[0];
   assign bus.m1_grnt  = r_grnt[1];
   assign bus.m2_grnt  = r_grnt[2];
   assign bus.m3_grnt  = r_grnt[3];
   assign bus.owner    = r_owner;
   assign bus.grnt_chg = r_grnt_chg;

endmodule

`default_nettype wire
